// File: rtl/axi_hp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_hp_pkg
// Brief    : Shared AXI3 constants, clog2 helper and AR state type for HP ports
// Revision : 1.0 - initial release
// ============================================================================
package axi_hp_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [3:0] AXI_CACHE_BUFMOD = 4'b0011;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam int MAX_OUTSTANDING_DEF = 4;
    localparam int CNT_W_DEF           = clog2(MAX_OUTSTANDING_DEF + 1);

    typedef enum logic [0:0] {
        AR_IDLE  = 1'b0,
        AR_ISSUE = 1'b1
    } ar_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_hp_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_hp_rd_arbiter_if
// Brief    : Client request/return bundle plus AXI3 AR/R channel of one HP port
// Revision : 1.0 - initial release
// ============================================================================
interface axi_hp_rd_arbiter_if #(
    parameter int NUM_CH         = 4,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 6,
    parameter int LEN_WIDTH      = 4
) ();
    logic [NUM_CH-1:0]                req_valid;
    logic [NUM_CH-1:0]                req_ready;
    logic [NUM_CH*AXI_ADDR_WIDTH-1:0] req_addr;
    logic [NUM_CH*LEN_WIDTH-1:0]      req_len;
    logic [AXI_DATA_WIDTH-1:0]        rd_data;
    logic                             rd_last;
    logic [NUM_CH-1:0]                rd_valid;
    logic [NUM_CH-1:0]                rd_ready;

    logic [AXI_ADDR_WIDTH-1:0]        ARADDR;
    logic [LEN_WIDTH-1:0]             ARLEN;
    logic [2:0]                       ARSIZE;
    logic [1:0]                       ARBURST;
    logic [3:0]                       ARCACHE;
    logic [AXI_ID_WIDTH-1:0]          ARID;
    logic                             ARVALID;
    logic                             ARREADY;
    logic [AXI_DATA_WIDTH-1:0]        RDATA;
    logic [AXI_ID_WIDTH-1:0]          RID;
    logic                             RLAST;
    logic [1:0]                       RRESP;
    logic                             RVALID;
    logic                             RREADY;

    logic [1:0]                       err_sticky;
    logic                             err_clear;
    logic                             busy;

    modport master (
        input  req_valid, req_addr, req_len, rd_ready,
        input  ARREADY, RDATA, RID, RLAST, RRESP, RVALID, err_clear,
        output req_ready, rd_data, rd_last, rd_valid,
        output ARADDR, ARLEN, ARSIZE, ARBURST, ARCACHE, ARID, ARVALID, RREADY,
        output err_sticky, busy
    );

    modport slave (
        output req_valid, req_addr, req_len, rd_ready,
        output ARREADY, RDATA, RID, RLAST, RRESP, RVALID, err_clear,
        input  req_ready, rd_data, rd_last, rd_valid,
        input  ARADDR, ARLEN, ARSIZE, ARBURST, ARCACHE, ARID, ARVALID, RREADY,
        input  err_sticky, busy
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick of first request at/after pointer
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [NUM_CH-1:0] o_grant,
    output logic [IDX_W-1:0]  o_grant_idx,
    output logic              o_grant_any
);
    int w_j;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_any = 1'b0;
        w_j         = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_j = (int'(i_ptr) + i) % NUM_CH;
            if (!o_grant_any && i_req[w_j]) begin
                o_grant_any  = 1'b1;
                o_grant[w_j] = 1'b1;
                o_grant_idx  = w_j[IDX_W-1:0];
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/axi_hp_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_hp_rd_arbiter
// Brief    : Round-robin multi-client read front-end for one AXI3 HP slave port
// Revision : 1.0 - initial release
// ============================================================================
module axi_hp_rd_arbiter
    import axi_hp_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_ID_WIDTH    = 6,
    parameter int MAX_OUTSTANDING = 4,
    parameter int LEN_WIDTH       = 4
) (
    input  logic                ACLK,
    input  logic                ARESET,
    axi_hp_rd_arbiter_if.master bus
);
    localparam int                 c_idx_w   = clog2(NUM_CH);
    localparam int                 c_cnt_w   = clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_cnt_w-1:0] c_max_cnt = c_cnt_w'(MAX_OUTSTANDING);
    localparam logic [2:0]         c_arsize  = 3'(clog2(AXI_DATA_WIDTH / 8));

    ar_state_t                 r_state;
    logic [c_idx_w-1:0]        r_ptr;
    logic [c_idx_w-1:0]        r_idx;
    logic [AXI_ADDR_WIDTH-1:0] r_araddr;
    logic [LEN_WIDTH-1:0]      r_arlen;
    logic                      r_arvalid;
    logic [NUM_CH-1:0]         r_req_ready;
    logic [c_cnt_w-1:0]        r_cnt [NUM_CH];
    logic [1:0]                r_err;

    logic [NUM_CH-1:0]  w_eligible;
    logic [NUM_CH-1:0]  w_grant;
    logic [c_idx_w-1:0] w_grant_idx;
    logic               w_grant_any;
    logic               w_rid_ok;
    logic [c_idx_w-1:0] w_rid_idx;
    logic               w_r_hs;
    logic               w_ar_hs;
    logic [NUM_CH-1:0]  w_inc;
    logic [NUM_CH-1:0]  w_dec;
    logic               w_spurious;
    logic               w_cnt_nz;
    logic [1:0]         w_err_set;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_eligible[i] = bus.req_valid[i] && (r_cnt[i] < c_max_cnt);
        end
    end

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (c_idx_w)
    ) u_rr_arbiter (
        .i_req       (w_eligible),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_grant_any (w_grant_any)
    );

    // AR issue FSM: one IDLE cycle to arbitrate, then hold the burst until ARREADY.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state     <= AR_IDLE;
            r_ptr       <= '0;
            r_idx       <= '0;
            r_araddr    <= '0;
            r_arlen     <= '0;
            r_arvalid   <= 1'b0;
            r_req_ready <= '0;
        end else begin
            r_req_ready <= '0;
            case (r_state)
                AR_IDLE: begin
                    if (w_grant_any) begin
                        r_req_ready <= w_grant;
                        r_araddr    <= bus.req_addr[w_grant_idx * AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                        r_arlen     <= bus.req_len[w_grant_idx * LEN_WIDTH +: LEN_WIDTH];
                        r_idx       <= w_grant_idx;
                        r_arvalid   <= 1'b1;
                        r_state     <= AR_ISSUE;
                    end
                end
                AR_ISSUE: begin
                    if (bus.ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_ptr     <= (r_idx == c_idx_w'(NUM_CH - 1)) ? '0 : r_idx + 1'b1;
                        r_state   <= AR_IDLE;
                    end
                end
                default: r_state <= AR_IDLE;
            endcase
        end
    end

    assign bus.ARADDR    = r_araddr;
    assign bus.ARLEN     = r_arlen;
    assign bus.ARID      = AXI_ID_WIDTH'(r_idx);
    assign bus.ARVALID   = r_arvalid;
    assign bus.ARSIZE    = c_arsize;
    assign bus.ARBURST   = AXI_BURST_INCR;
    assign bus.ARCACHE   = AXI_CACHE_BUFMOD;
    assign bus.req_ready = r_req_ready;

    // Beats carrying an unknown RID are always accepted so the port never stalls.
    assign w_rid_ok  = bus.RID < AXI_ID_WIDTH'(NUM_CH);
    assign w_rid_idx = bus.RID[c_idx_w-1:0];

    always_comb begin
        bus.rd_valid = '0;
        bus.RREADY   = 1'b1;
        if (w_rid_ok) begin
            bus.rd_valid[w_rid_idx] = bus.RVALID;
            bus.RREADY              = bus.rd_ready[w_rid_idx];
        end
    end

    assign bus.rd_data = bus.RDATA;
    assign bus.rd_last = bus.RLAST;

    assign w_r_hs  = bus.RVALID && bus.RREADY;
    assign w_ar_hs = r_arvalid && bus.ARREADY;
    assign w_inc   = w_ar_hs ? (NUM_CH'(1) << r_idx) : '0;
    assign w_dec   = (w_r_hs && bus.RLAST && w_rid_ok) ? (NUM_CH'(1) << w_rid_idx) : '0;

    always_comb begin
        w_spurious = 1'b0;
        w_cnt_nz   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_dec[i] && !w_inc[i] && (r_cnt[i] == '0)) w_spurious = 1'b1;
            if (r_cnt[i] != '0)                            w_cnt_nz   = 1'b1;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + c_cnt_w'(1);
                end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - c_cnt_w'(1);
                end
            end
        end
    end

    assign w_err_set[0] = w_r_hs && (bus.RRESP != AXI_RESP_OKAY);
    assign w_err_set[1] = (bus.RVALID && !w_rid_ok) || w_spurious;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_err <= '0;
        end else if (bus.err_clear) begin
            r_err <= '0;
        end else begin
            r_err <= r_err | w_err_set;
        end
    end

    assign bus.err_sticky = r_err;
    assign bus.busy       = w_cnt_nz || r_arvalid;
endmodule
`default_nettype wire
